// File: rtl/triangle_wave_analyzer_if.sv
// Sample stream and analysis results between a triangle source and its checker.
// The master drives samples and observes results; the slave is the analyzer.
interface triangle_wave_analyzer_if #(
    parameter int WIDTH    = 5,
    parameter int PERIOD_W = 8
);
    logic                sample_valid;
    logic [WIDTH-1:0]    sample;
    logic                locked;
    logic                dir;
    logic                peak;
    logic                trough;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                err;
    logic [7:0]          err_count;

    modport master (
        output sample_valid, sample,
        input  locked, dir, peak, trough, period, period_valid, err, err_count
    );

    modport slave (
        input  sample_valid, sample,
        output locked, dir, peak, trough, period, period_valid, err, err_count
    );
endinterface

// File: rtl/triangle_wave_analyzer.sv
// Checks an incoming triangle sample stream for +/-1 steps with reversals only at the rails,
// locks onto clean streams, flags peaks/troughs, measures trough-to-trough period, counts errors.
module triangle_wave_analyzer #(
    parameter int WIDTH      = 5,
    parameter int LOCK_STEPS = 4,
    parameter int PERIOD_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    triangle_wave_analyzer_if.slave bus
);
    typedef enum logic [1:0] {ACQ, RISE, FALL} state_t;

    localparam int                  CNT_W      = $clog2(LOCK_STEPS + 1);
    localparam logic [WIDTH-1:0]    MAX        = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]    LOCK_CNT   = CNT_W'(LOCK_STEPS);
    localparam logic [PERIOD_W-1:0] PERIOD_SAT = {PERIOD_W{1'b1}};
    localparam logic [7:0]          ERR_SAT    = 8'hFF;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    prev_reg, prev_next;
    logic                have_prev_reg, have_prev_next;
    logic                dir_reg, dir_next;
    logic [CNT_W-1:0]    step_cnt_reg, step_cnt_next;
    logic [PERIOD_W-1:0] per_cnt_reg, per_cnt_next;
    logic                first_trough_reg, first_trough_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic                period_valid_reg, period_valid_next;
    logic                peak_reg, peak_next;
    logic                trough_reg, trough_next;
    logic                err_reg, err_next;
    logic [7:0]          err_count_reg, err_count_next;

    logic [WIDTH-1:0]    sample;
    logic                step_up;
    logic                step_dn;
    logic [CNT_W-1:0]    run_len;
    logic [PERIOD_W-1:0] per_cnt_inc;
    logic [7:0]          err_count_inc;

    assign sample = bus.sample;

    // Rail guards keep the +/-1 comparison from wrapping around the sample range.
    assign step_up = (prev_reg != MAX) && (sample == prev_reg + WIDTH'(1));
    assign step_dn = (prev_reg != '0)  && (sample == prev_reg - WIDTH'(1));

    // A zero count means no usable prior step, so any legal step restarts the run at 1.
    assign run_len = ((step_cnt_reg != '0) && (step_up == dir_reg)) ? step_cnt_reg + CNT_W'(1)
                                                                     : CNT_W'(1);

    assign per_cnt_inc   = (per_cnt_reg == PERIOD_SAT) ? PERIOD_SAT : per_cnt_reg + PERIOD_W'(1);
    assign err_count_inc = (err_count_reg == ERR_SAT) ? ERR_SAT : err_count_reg + 8'd1;

    always_comb begin
        state_next        = state_reg;
        prev_next         = prev_reg;
        have_prev_next    = have_prev_reg;
        dir_next          = dir_reg;
        step_cnt_next     = step_cnt_reg;
        per_cnt_next      = per_cnt_reg;
        first_trough_next = first_trough_reg;
        period_next       = period_reg;
        period_valid_next = 1'b0;
        peak_next         = 1'b0;
        trough_next       = 1'b0;
        err_next          = 1'b0;
        err_count_next    = err_count_reg;

        if (bus.sample_valid) begin
            prev_next      = sample;
            have_prev_next = 1'b1;
            if (have_prev_reg) begin
                case (state_reg)
                    ACQ: begin
                        if (step_up || step_dn) begin
                            dir_next = step_up;
                            if (run_len == LOCK_CNT) begin
                                step_cnt_next     = '0;
                                first_trough_next = 1'b1;
                                per_cnt_next      = '0;
                                // A lock that lands on a rail must turn around on the next sample.
                                if (step_up) begin
                                    state_next = (sample == MAX) ? FALL : RISE;
                                end else begin
                                    state_next = (sample == '0) ? RISE : FALL;
                                end
                            end else begin
                                step_cnt_next = run_len;
                            end
                        end else begin
                            step_cnt_next = '0;
                        end
                    end
                    RISE: begin
                        if (step_up) begin
                            dir_next     = 1'b1;
                            per_cnt_next = per_cnt_inc;
                            if (sample == MAX) begin
                                peak_next  = 1'b1;
                                state_next = FALL;
                            end
                        end else begin
                            err_next       = 1'b1;
                            err_count_next = err_count_inc;
                            state_next     = ACQ;
                            step_cnt_next  = '0;
                        end
                    end
                    FALL: begin
                        if (step_dn) begin
                            dir_next = 1'b0;
                            if (sample == '0) begin
                                trough_next = 1'b1;
                                state_next  = RISE;
                                // The first trough after lock only starts the measurement.
                                if (!first_trough_reg) begin
                                    period_next       = per_cnt_inc;
                                    period_valid_next = 1'b1;
                                end
                                per_cnt_next      = '0;
                                first_trough_next = 1'b0;
                            end else begin
                                per_cnt_next = per_cnt_inc;
                            end
                        end else begin
                            err_next       = 1'b1;
                            err_count_next = err_count_inc;
                            state_next     = ACQ;
                            step_cnt_next  = '0;
                        end
                    end
                    default: begin
                        state_next    = ACQ;
                        step_cnt_next = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ACQ;
            prev_reg         <= '0;
            have_prev_reg    <= 1'b0;
            dir_reg          <= 1'b0;
            step_cnt_reg     <= '0;
            per_cnt_reg      <= '0;
            first_trough_reg <= 1'b0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            peak_reg         <= 1'b0;
            trough_reg       <= 1'b0;
            err_reg          <= 1'b0;
            err_count_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            prev_reg         <= prev_next;
            have_prev_reg    <= have_prev_next;
            dir_reg          <= dir_next;
            step_cnt_reg     <= step_cnt_next;
            per_cnt_reg      <= per_cnt_next;
            first_trough_reg <= first_trough_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            peak_reg         <= peak_next;
            trough_reg       <= trough_next;
            err_reg          <= err_next;
            err_count_reg    <= err_count_next;
        end
    end

    assign bus.locked       = (state_reg != ACQ);
    assign bus.dir          = dir_reg;
    assign bus.peak         = peak_reg;
    assign bus.trough       = trough_reg;
    assign bus.period       = period_reg;
    assign bus.period_valid = period_valid_reg;
    assign bus.err          = err_reg;
    assign bus.err_count    = err_count_reg;
endmodule

// File: tb/tb_triangle_wave_analyzer.sv
// Bench for triangle_wave_analyzer: vector table, directed corner sequences and a random
// stream, all compared against a history-based reference model.
module tb_triangle_wave_analyzer;
    localparam int WIDTH      = 5;
    localparam int LOCK_STEPS = 4;
    localparam int PERIOD_W   = 8;
    localparam int MAX        = 31;

    logic clk;
    logic rst;

    triangle_wave_analyzer_if #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W)) bus ();

    triangle_wave_analyzer #(
        .WIDTH(WIDTH), .LOCK_STEPS(LOCK_STEPS), .PERIOD_W(PERIOD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: keeps every accepted sample and decides lock by looking back over
    // the history for a run of same-direction unit steps.
    bit m_locked, m_dir, m_peak, m_trough, m_pv, m_err;
    int m_period, m_errcnt;
    int hist[$];
    int seg_start;
    int last_trough;

    typedef struct {
        bit v;
        int s;
        bit lk;
        bit dr;
        bit pk;
        bit tr;
        bit er;
        int ec;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [21:0] dut_vec();
        return {bus.locked, bus.dir, bus.peak, bus.trough, bus.period_valid, bus.err,
                bus.period, bus.err_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_dir = 0; m_peak = 0; m_trough = 0; m_pv = 0; m_err = 0;
        m_period = 0; m_errcnt = 0;
        hist.delete();
        seg_start   = 0;
        last_trough = -1;
    endtask

    task automatic model_step(input bit v, input int s);
        int n, p, st, exp_st, run, k;
        m_peak = 0; m_trough = 0; m_pv = 0; m_err = 0;
        if (!v) return;
        hist.push_back(s);
        n = hist.size() - 1;
        if (n == 0) return;
        p  = hist[n-1];
        st = s - p;
        if (m_locked) begin
            // A triangle turns at the rails and otherwise keeps going the same way.
            exp_st = (p == MAX) ? -1 : (p == 0) ? 1 : (m_dir ? 1 : -1);
            if (st == exp_st) begin
                m_dir = (st == 1);
                if (s == MAX) m_peak = 1;
                if (s == 0) begin
                    m_trough = 1;
                    if (last_trough >= 0) begin
                        m_pv     = 1;
                        m_period = (n - last_trough > 255) ? 255 : n - last_trough;
                    end
                    last_trough = n;
                end
            end else begin
                m_err = 1;
                if (m_errcnt < 255) m_errcnt++;
                m_locked  = 0;
                seg_start = n;
            end
        end else if (st == 1 || st == -1) begin
            m_dir = (st == 1);
            run = 0;
            k   = n;
            while (k - 1 >= seg_start && hist[k] - hist[k-1] == st) begin
                run++;
                k--;
            end
            if (run >= LOCK_STEPS) begin
                m_locked    = 1;
                last_trough = -1;
            end
        end
    endtask

    task automatic compare_model(input string name);
        logic [21:0] expv;
        logic [7:0]  p8, e8;
        p8   = m_period[7:0];
        e8   = m_errcnt[7:0];
        expv = {m_locked, m_dir, m_peak, m_trough, m_pv, m_err, p8, e8};
        check(name, 32'(dut_vec()), 32'(expv));
    endtask

    task automatic send(input bit v, input int s);
        @(negedge clk);
        bus.sample_valid = v;
        bus.sample       = s[WIDTH-1:0];
        @(posedge clk);
        #1;
        model_step(v, s);
        compare_model($sformatf("model v=%0d s=%0d", v, s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int tri_at(input int i);
        int m;
        m = i % 62;
        return (m <= MAX) ? m : 62 - m;
    endfunction

    initial begin
        int b, g, gdir, r;
        bit v;

        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample = '0;
        model_reset();

        // Lock on a rising stream, break it, relock, then a repeated sample.
        for (int i = 0; i <= 3; i++) tbl.push_back('{1, i, 0, (i != 0), 0, 0, 0, 0});
        for (int i = 4; i <= 10; i++) tbl.push_back('{1, i, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 13, 0, 1, 0, 0, 1, 1});
        for (int i = 14; i <= 16; i++) tbl.push_back('{1, i, 0, 1, 0, 0, 0, 1});
        tbl.push_back('{1, 17, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 3, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{1, 17, 0, 1, 0, 0, 1, 2});

        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].v, tbl[i].s);
            check($sformatf("tbl[%0d]", i),
                  32'({bus.locked, bus.dir, bus.peak, bus.trough, bus.err, bus.err_count}),
                  32'({tbl[i].lk, tbl[i].dr, tbl[i].pk, tbl[i].tr, tbl[i].er, 8'(tbl[i].ec)}));
        end

        // Relock rising, peak, then asynchronous reset while falling at 17.
        for (int s = 18; s <= MAX; s++) send(1, s);
        for (int s = 30; s >= 17; s--) send(1, s);
        check("falling_locked", 32'({bus.locked, bus.dir}), 32'(2'b10));
        @(negedge clk);
        bus.sample_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send(1, 17);
        for (int s = 16; s >= 14; s--) send(1, s);
        check("relock_not_yet", 32'(bus.locked), 32'd0);
        send(1, 13);
        check("relock_falling", 32'({bus.locked, bus.dir}), 32'(2'b10));

        // Ideal stream with valid only every third cycle: period counts samples.
        do_reset();
        for (int i = 0; i <= 124; i++) begin
            send(1, tri_at(i));
            if (i == 3)   check("gap_lock_pre", 32'(bus.locked), 32'd0);
            if (i == 4)   check("gap_lock", 32'(bus.locked), 32'd1);
            if (i == 31)  check("gap_peak", 32'(bus.peak), 32'd1);
            if (i == 62)  check("gap_trough1", 32'({bus.trough, bus.period_valid}), 32'(2'b10));
            if (i == 124) check("gap_period", 32'({bus.trough, bus.period_valid, bus.period}),
                                32'({2'b11, 8'd62}));
            send(0, 0);
            send(0, 0);
        end

        // Repeated sample, then an illegal turn right after a peak.
        for (int s = 1; s <= 20; s++) send(1, s);
        send(1, 20);
        check("repeat_err", 32'({bus.err, bus.locked, bus.err_count}), 32'({2'b10, 8'd1}));
        for (int s = 21; s <= MAX; s++) send(1, s);
        check("peak31", 32'({bus.peak, bus.err}), 32'(2'b10));
        send(1, 0);
        check("zero_after_peak", 32'({bus.err, bus.trough, bus.err_count}), 32'({2'b10, 8'd2}));

        // err only fires while locked, so each error round relocks first.
        for (int rd = 0; rd < 260; rd++) begin
            b = $urandom_range(0, 20);
            for (int s = b; s <= b + 4; s++) send(1, s);
            send(1, b + 4);
        end
        check("err_saturated", 32'(bus.err_count), 32'd255);
        for (int s = 3; s <= 7; s++) send(1, s);
        send(1, 7);
        check("err_stays_saturated", 32'({bus.err, bus.err_count}), 32'({1'b1, 8'd255}));

        // Random stream: mostly a clean triangle with jumps, repeats and idle cycles.
        do_reset();
        g = 0;
        gdir = 1;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                r = $urandom_range(0, 39);
                if (r == 0) begin
                    g = $urandom_range(0, MAX);
                end else if (r != 1) begin
                    if (g == MAX) gdir = 0;
                    if (g == 0)   gdir = 1;
                    g = gdir ? g + 1 : g - 1;
                end
            end
            send(v, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
